// File: rtl/filter_pkg.sv
// Shared definitions for the fixed-point low-pass filter family.
package filter_pkg;

  localparam int unsigned DEF_WIDTH     = 32;
  localparam int unsigned DEF_FRAC_BITS = 8;

  typedef enum logic {
    FILT_LOWPASS = 1'b0,
    FILT_BYPASS  = 1'b1
  } filt_mode_e;

  // Width of a channel state word: integer part plus fractional guard bits.
  function automatic int unsigned state_w(input int unsigned width, input int unsigned frac);
    return width + frac;
  endfunction

endpackage

// File: rtl/filter_lp_core.sv
// Combinational first-order low-pass update: s_new = s + (d >>> shift), or s + d in bypass.
module filter_lp_core
  import filter_pkg::*;
#(
  parameter int unsigned WIDTH     = DEF_WIDTH,
  parameter int unsigned FRAC_BITS = DEF_FRAC_BITS,
  parameter int unsigned SHIFT_W   = 5
) (
  input  logic signed [state_w(WIDTH, FRAC_BITS)-1:0] s,
  input  logic signed [state_w(WIDTH, FRAC_BITS):0]   d,
  input  logic        [SHIFT_W-1:0]                   shift,
  input  filt_mode_e                                  mode,
  output logic signed [state_w(WIDTH, FRAC_BITS)-1:0] s_new,
  output logic signed [WIDTH-1:0]                     out_data
);

  localparam int unsigned SW = state_w(WIDTH, FRAC_BITS);

  logic signed [SW:0] s_ext;
  logic signed [SW:0] step;
  logic signed [SW:0] sum;

  // s + d equals the shifted input exactly, so bypass needs no separate x operand.
  always_comb begin
    s_ext    = {s[SW-1], s};
    step     = (mode == FILT_BYPASS) ? d : (d >>> shift);
    sum      = s_ext + step;
    s_new    = sum[SW-1:0];
    out_data = s_new[SW-1:FRAC_BITS];
  end

endmodule

// File: rtl/filter_lowpass_mc.sv
// Multi-channel time-multiplexed first-order low-pass filter, 2-stage pipeline with
// per-channel state, same-channel forwarding and valid/ready handshaking.
module filter_lowpass_mc
  import filter_pkg::*;
#(
  parameter int unsigned WIDTH     = DEF_WIDTH,
  parameter int unsigned NUM_CH    = 4,
  parameter int unsigned FRAC_BITS = DEF_FRAC_BITS,
  parameter int unsigned SHIFT_W   = 5,
  parameter int unsigned CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [SHIFT_W-1:0]      cfg_shift,
  input  logic                    cfg_bypass,
  input  logic                    clear_all,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [CH_W-1:0]         in_ch,
  input  logic signed [WIDTH-1:0] in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [CH_W-1:0]         out_ch,
  output logic signed [WIDTH-1:0] out_data
);

  localparam int unsigned SW = state_w(WIDTH, FRAC_BITS);
  localparam int unsigned DW = SW + 1;

  logic signed [SW-1:0] state [NUM_CH];

  logic                 p_valid;
  logic [CH_W-1:0]      p_ch;
  logic signed [DW-1:0] p_d;
  logic [SHIFT_W-1:0]   p_shift;
  filt_mode_e           p_mode;

  logic                 adv;
  logic                 xfer;
  logic                 ch_ok;
  logic                 fwd;
  logic signed [SW-1:0] s_cur;
  logic signed [SW-1:0] s_in;
  logic signed [SW-1:0] x_in;
  logic signed [DW-1:0] d_in;
  logic signed [SW-1:0] s_new;
  logic signed [WIDTH-1:0] core_out;

  // Stage 1: handshake, state read with forwarding from stage 2, difference.
  always_comb begin
    adv      = !out_valid || out_ready;
    in_ready = adv && !clear_all && rst;
    xfer     = in_valid && in_ready;
    ch_ok    = 32'(in_ch) < NUM_CH;
    fwd      = p_valid && (p_ch == in_ch);
    s_cur    = state[p_ch];
    s_in     = fwd ? s_new : state[in_ch];
    x_in     = {in_data, {FRAC_BITS{1'b0}}};
    d_in     = {x_in[SW-1], x_in} - {s_in[SW-1], s_in};
  end

  filter_lp_core #(
    .WIDTH     (WIDTH),
    .FRAC_BITS (FRAC_BITS),
    .SHIFT_W   (SHIFT_W)
  ) u_core (
    .s        (s_cur),
    .d        (p_d),
    .shift    (p_shift),
    .mode     (p_mode),
    .s_new    (s_new),
    .out_data (core_out)
  );

  // Pipeline, state array and output register; flush overrides any advance.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < int'(NUM_CH); i++) state[i] <= '0;
      p_valid   <= 1'b0;
      p_ch      <= '0;
      p_d       <= '0;
      p_shift   <= '0;
      p_mode    <= FILT_LOWPASS;
      out_valid <= 1'b0;
      out_ch    <= '0;
      out_data  <= '0;
    end else if (clear_all) begin
      for (int i = 0; i < int'(NUM_CH); i++) state[i] <= '0;
      p_valid   <= 1'b0;
      out_valid <= 1'b0;
    end else if (adv) begin
      p_valid <= xfer && ch_ok;
      if (xfer) begin
        p_ch    <= in_ch;
        p_d     <= d_in;
        p_shift <= cfg_shift;
        p_mode  <= cfg_bypass ? FILT_BYPASS : FILT_LOWPASS;
      end
      out_valid <= p_valid;
      if (p_valid) begin
        state[p_ch] <= s_new;
        out_ch      <= p_ch;
        out_data    <= core_out;
      end
    end
  end

endmodule

// File: tb/tb_filter_lowpass_mc.sv
// Scoreboard bench for filter_lowpass_mc: directed vectors, decoupled output monitor.
module tb_filter_lowpass_mc;

  logic              clk = 1'b0;
  logic              rst;
  logic [4:0]        cfg_shift;
  logic              cfg_bypass;
  logic              clear_all;
  logic              in_valid;
  logic              in_ready;
  logic [1:0]        in_ch;
  logic signed [31:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [1:0]        out_ch;
  logic signed [31:0] out_data;

  typedef struct packed {
    logic [1:0] ch;
    int         data;
  } exp_t;

  exp_t    sb[$];
  int      n_vec  = 0;
  int      n_fail = 0;
  longint  mdl[4];
  int      last_data = 0;

  always #5 clk = ~clk;

  filter_lowpass_mc dut (
    .clk        (clk),
    .rst        (rst),
    .cfg_shift  (cfg_shift),
    .cfg_bypass (cfg_bypass),
    .clear_all  (clear_all),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_ch      (in_ch),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_ch     (out_ch),
    .out_data   (out_data)
  );

  task automatic check(input string name, input longint act, input longint exp);
    n_vec++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Floor division by 2^sh, written independently of arithmetic shifts.
  function automatic longint fdiv(input longint a, input int sh);
    longint p, q;
    p = longint'(1) << sh;
    q = a / p;
    if (a < 0 && q * p != a) q = q - 1;
    return q;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) mdl[i] = 0;
  endtask

  task automatic send(input int ch, input int data, input int sh, input bit byp,
                      input bit hand_en, input int hand);
    longint x, s;
    int k;
    exp_t e;
    in_valid   = 1'b1;
    in_ch      = 2'(ch);
    in_data    = data;
    cfg_shift  = 5'(sh);
    cfg_bypass = byp;
    k = 0;
    @(negedge clk);
    while (!in_ready && k < 100) begin
      k++;
      @(negedge clk);
    end
    if (!in_ready) begin
      check("in_ready_timeout", 0, 1);
    end else begin
      x = longint'(data) * 256;
      s = byp ? x : mdl[ch] + fdiv(x - mdl[ch], sh);
      mdl[ch] = s;
      e.ch    = 2'(ch);
      e.data  = hand_en ? hand : int'(fdiv(s, 8));
      sb.push_back(e);
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (sb.size() != 0 && k < 50) begin
      @(posedge clk);
      k++;
    end
    check("drain_empty", sb.size(), 0);
    @(posedge clk);
    #1;
  endtask

  task automatic do_clear();
    clear_all = 1'b1;
    @(negedge clk);
    check("clear_in_ready", in_ready, 0);
    @(posedge clk);
    #1 clear_all = 1'b0;
    model_reset();
    sb.delete();
  endtask

  // Monitor: every accepted output is popped and compared.
  always @(negedge clk) begin
    if (rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_output", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("out_ch", out_ch, e.ch);
        check("out_data", out_data, e.data);
        last_data = out_data;
      end
    end
  end

  initial begin
    rst = 1'b0; cfg_shift = '0; cfg_bypass = 1'b0; clear_all = 1'b0;
    in_valid = 1'b0; in_ch = '0; in_data = '0; out_ready = 1'b1;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_ch", out_ch, 0);
    @(posedge clk);
    #1 rst = 1'b1;

    // Step response on ch0 with latency check on the first sample.
    send(0, 1000, 4, 1'b0, 1'b1, 62);
    @(negedge clk);
    check("latency_edge1", out_valid, 0);
    @(negedge clk);
    check("latency_edge2", out_valid, 1);
    @(posedge clk);
    #1;
    send(0, 1000, 4, 1'b0, 1'b1, 121);
    send(0, 1000, 4, 1'b0, 1'b1, 176);
    for (int i = 0; i < 197; i++) send(0, 1000, 4, 1'b0, 1'b0, 0);
    drain();
    check("step_converged", (last_data >= 999 && last_data <= 1000), 1);

    // Channel isolation and back-to-back same-channel forwarding.
    do_clear();
    send(0, 1000, 4, 1'b0, 1'b1, 62);
    send(1, -1000, 4, 1'b0, 1'b1, -63);
    send(0, 1000, 4, 1'b0, 1'b1, 121);
    send(1, -1000, 4, 1'b0, 1'b1, -122);
    send(0, 1000, 4, 1'b0, 1'b1, 176);
    send(1, -1000, 4, 1'b0, 1'b1, -177);
    for (int i = 0; i < 4; i++) begin
      send(0, 1000, 4, 1'b0, 1'b0, 0);
      send(1, -1000, 4, 1'b0, 1'b0, 0);
    end
    send(2, 300, 3, 1'b0, 1'b0, 0);
    send(2, -700, 3, 1'b0, 1'b0, 0);
    send(2, 12345, 1, 1'b0, 1'b0, 0);
    send(2, 5, 2, 1'b0, 1'b0, 0);
    send(2, -40000, 0, 1'b0, 1'b0, 0);
    send(2, 77, 30, 1'b0, 1'b0, 0);
    send(2, 77, 5, 1'b0, 1'b0, 0);
    drain();

    // Backpressure mid-stream.
    fork
      begin
        for (int i = 0; i < 10; i++) send(3, 100 * i - 300, 2, 1'b0, 1'b0, 0);
      end
      begin
        repeat (4) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (5) begin
          @(negedge clk);
          check("stall_out_valid", out_valid, 1);
          check("stall_in_ready", in_ready, 0);
          check("stall_out_ch", out_ch, sb[0].ch);
          check("stall_out_data", out_data, sb[0].data);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();

    // Bypass then normal filtering from the bypass-loaded state.
    send(3, 5000, 4, 1'b1, 1'b1, 5000);
    send(3, 0, 4, 1'b0, 1'b1, 4687);
    drain();

    // Flush with samples in both stages.
    send(1, 777, 4, 1'b0, 1'b0, 0);
    send(2, -555, 4, 1'b0, 1'b0, 0);
    out_ready = 1'b0;
    do_clear();
    out_ready = 1'b1;
    @(negedge clk);
    check("clear_out_valid", out_valid, 0);
    @(posedge clk);
    #1;
    send(1, 1000, 4, 1'b0, 1'b1, 62);
    drain();

    // Asynchronous reset between edges with samples in flight.
    send(0, 1000, 4, 1'b0, 1'b0, 0);
    send(0, 1000, 4, 1'b0, 1'b0, 0);
    #2 rst = 1'b0;
    #1;
    check("arst_out_valid", out_valid, 0);
    check("arst_out_data", out_data, 0);
    check("arst_in_ready", in_ready, 0);
    sb.delete();
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    send(0, 1000, 4, 1'b0, 1'b1, 62);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
